// File: rtl/execute_shift_unit_if.sv
// Execute shift unit handshake bundle.
// Upstream: iVALID/oBUSY/iCMD/iDATA/iAMOUNT; downstream: oVALID/iBUSY/oDATA/oFLAGS.
interface execute_shift_unit_if;
  logic        iVALID;
  logic        oBUSY;
  logic [2:0]  iCMD;
  logic [31:0] iDATA;
  logic [4:0]  iAMOUNT;
  logic        oVALID;
  logic        iBUSY;
  logic [31:0] oDATA;
  logic [2:0]  oFLAGS;

  modport master (
    output iVALID, iCMD, iDATA, iAMOUNT, iBUSY,
    input  oBUSY, oVALID, oDATA, oFLAGS
  );

  modport slave (
    input  iVALID, iCMD, iDATA, iAMOUNT, iBUSY,
    output oBUSY, oVALID, oDATA, oFLAGS
  );
endinterface

// File: rtl/execute_shift_unit.sv
// Pipelined 32-bit shifter/rotator with zero/carry/sign flags.
// Ports: iCLOCK, inRESET, iRESET_SYNC, iFLUSH, bus (slave); EXE_SHIFT_TWO_STAGE_EN -> 2 stages.
module execute_shift_unit (
  input  logic iCLOCK,
  input  logic inRESET,
  input  logic iRESET_SYNC,
  input  logic iFLUSH,
  execute_shift_unit_if.slave bus
);

  localparam logic [2:0] C_LSL = 3'd1;
  localparam logic [2:0] C_LSR = 3'd2;
  localparam logic [2:0] C_ASR = 3'd3;
  localparam logic [2:0] C_ROL = 3'd4;
  localparam logic [2:0] C_ROR = 3'd5;

  function automatic logic [32:0] shift_part(
    input logic [2:0]  cmd,
    input logic [31:0] d,
    input logic [4:0]  s
  );
    logic [31:0] r;
    logic        cy;
    logic [4:0]  up;
    logic [4:0]  dn;
    r  = d;
    cy = 1'b0;
    up = 5'd0 - s;
    dn = s - 5'd1;
    case (cmd)
      C_LSL: begin
        r  = d << s;
        cy = (s != 5'd0) && d[up];
      end
      C_LSR: begin
        r  = d >> s;
        cy = (s != 5'd0) && d[dn];
      end
      C_ASR: begin
        r  = 32'($signed(d) >>> s);
        cy = (s != 5'd0) && d[dn];
      end
      C_ROL: r = (d << s) | (d >> (6'd32 - {1'b0, s}));
      C_ROR: r = (d >> s) | (d << (6'd32 - {1'b0, s}));
      default: ;
    endcase
    return {cy, r};
  endfunction

  // Shifts keep the coarse carry when the fine step moves nothing.
  function automatic logic [34:0] finish_op(
    input logic [2:0]  cmd,
    input logic [31:0] p,
    input logic [2:0]  f,
    input logic        c1,
    input logic        nz
  );
    logic [32:0] t;
    logic [31:0] r;
    logic        cy;
    t  = shift_part(cmd, p, {2'b00, f});
    r  = t[31:0];
    cy = 1'b0;
    case (cmd)
      C_LSL, C_LSR, C_ASR: cy = (f != 3'd0) ? t[32] : c1;
      C_ROL: cy = nz & r[0];
      C_ROR: cy = nz & r[31];
      default: ;
    endcase
    return {r[31], cy, (r == 32'd0), r};
  endfunction

  logic [32:0] coarse;
  logic [34:0] fin;
  logic        nz;
  logic        out_adv;
  logic        accept;
  logic        out_valid;
  logic [31:0] out_data;
  logic [2:0]  out_flags;

  assign coarse  = shift_part(bus.iCMD, bus.iDATA,
                              {bus.iAMOUNT[4:3], 3'b000});
  assign nz      = |bus.iAMOUNT;
  assign out_adv = !out_valid || !bus.iBUSY;
  assign accept  = bus.iVALID && !bus.oBUSY && !iFLUSH;

  assign bus.oVALID = out_valid;
  assign bus.oDATA  = out_data;
  assign bus.oFLAGS = out_flags;

`ifdef EXE_SHIFT_TWO_STAGE_EN
  logic        s1_valid;
  logic [2:0]  s1_cmd;
  logic [31:0] s1_data;
  logic [2:0]  s1_fine;
  logic        s1_c1;
  logic        s1_nz;
  logic        s1_adv;

  assign s1_adv    = !s1_valid || out_adv;
  assign bus.oBUSY = s1_valid && !out_adv;
  assign fin       = finish_op(s1_cmd, s1_data, s1_fine,
                               s1_c1, s1_nz);

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      s1_valid <= 1'b0;
      s1_cmd   <= 3'd0;
      s1_data  <= 32'd0;
      s1_fine  <= 3'd0;
      s1_c1    <= 1'b0;
      s1_nz    <= 1'b0;
    end else if (iRESET_SYNC) begin
      s1_valid <= 1'b0;
      s1_cmd   <= 3'd0;
      s1_data  <= 32'd0;
      s1_fine  <= 3'd0;
      s1_c1    <= 1'b0;
      s1_nz    <= 1'b0;
    end else if (iFLUSH) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= accept;
      if (accept) begin
        s1_cmd  <= bus.iCMD;
        s1_data <= coarse[31:0];
        s1_fine <= bus.iAMOUNT[2:0];
        s1_c1   <= coarse[32];
        s1_nz   <= nz;
      end
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      out_valid <= 1'b0;
      out_data  <= 32'd0;
      out_flags <= 3'd0;
    end else if (iRESET_SYNC) begin
      out_valid <= 1'b0;
      out_data  <= 32'd0;
      out_flags <= 3'd0;
    end else if (iFLUSH) begin
      out_valid <= 1'b0;
    end else if (out_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data  <= fin[31:0];
        out_flags <= fin[34:32];
      end
    end
  end
`else
  assign bus.oBUSY = out_valid && bus.iBUSY;
  assign fin       = finish_op(bus.iCMD, coarse[31:0],
                               bus.iAMOUNT[2:0], coarse[32], nz);

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      out_valid <= 1'b0;
      out_data  <= 32'd0;
      out_flags <= 3'd0;
    end else if (iRESET_SYNC) begin
      out_valid <= 1'b0;
      out_data  <= 32'd0;
      out_flags <= 3'd0;
    end else if (iFLUSH) begin
      out_valid <= 1'b0;
    end else if (out_adv) begin
      out_valid <= accept;
      if (accept) begin
        out_data  <= fin[31:0];
        out_flags <= fin[34:32];
      end
    end
  end
`endif

endmodule

// File: tb/tb_execute_shift_unit.sv
// Testbench for execute_shift_unit: vector table, scoreboard, stall/flush/reset.
// Works for either build of EXE_SHIFT_TWO_STAGE_EN.
module tb_execute_shift_unit;

`ifdef EXE_SHIFT_TWO_STAGE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_sync = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  execute_shift_unit_if bus();

  execute_shift_unit dut (
    .iCLOCK     (clk),
    .inRESET    (rst_n),
    .iRESET_SYNC(rst_sync),
    .iFLUSH     (flush),
    .bus        (bus)
  );

  typedef struct {
    logic [31:0] d;
    logic [2:0]  f;
    int          cyc;
    bit          lat;
  } sb_t;

  typedef struct {
    logic [2:0]  c;
    logic [31:0] d;
    logic [4:0]  a;
    logic [31:0] ed;
    logic [2:0]  ef;
  } vec_t;

  sb_t         sb[$];
  vec_t        tab[16];
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [31:0] drv_d;
  logic [2:0]  drv_f;
  bit          chk_lat = 0;
  bit          rnd_busy = 0;
  bit          hold = 0;
  logic [31:0] hd;
  logic [2:0]  hf;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rnd_busy) bus.iBUSY = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [34:0] model(input logic [2:0] c,
                                        input logic [31:0] d,
                                        input logic [4:0] n);
    logic [63:0] t;
    logic [31:0] r;
    logic        cy;
    r  = d;
    cy = 1'b0;
    if (n != 5'd0) begin
      case (c)
        3'd1: begin
          t = {32'd0, d} << n; r = t[31:0]; cy = t[32];
        end
        3'd2: begin
          t = {d, 32'd0} >> n; r = t[63:32]; cy = t[31];
        end
        3'd3: begin
          t = 64'($signed({d, 32'd0}) >>> n);
          r = t[63:32]; cy = t[31];
        end
        3'd4: begin
          t = {d, d} << n; r = t[63:32]; cy = r[0];
        end
        3'd5: begin
          t = {d, d} >> n; r = t[31:0]; cy = r[31];
        end
        default: ;
      endcase
    end
    return {r[31], cy, (r == 32'd0), r};
  endfunction

  always @(negedge clk) begin
    sb_t e;
    if (!rst_n || rst_sync) begin
      sb.delete();
      hold = 0;
    end else begin
      if (hold && bus.oVALID) begin
        chk("hold_data", bus.oDATA, hd);
        chk("hold_flags", 32'(bus.oFLAGS), 32'(hf));
      end
      if (bus.oVALID && !bus.iBUSY) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_out: got %h expected none",
                   bus.oDATA);
        end else begin
          e = sb.pop_front();
          chk("out_data", bus.oDATA, e.d);
          chk("out_flags", 32'(bus.oFLAGS), 32'(e.f));
          if (e.lat) chk("latency", 32'(cyc - e.cyc), 32'(LAT));
        end
      end
      hold = bus.oVALID && bus.iBUSY;
      hd = bus.oDATA;
      hf = bus.oFLAGS;
      if (flush) sb.delete();
      else if (bus.iVALID && !bus.oBUSY)
        sb.push_back('{drv_d, drv_f, cyc, chk_lat});
    end
  end

  task automatic set_op(input logic [2:0] c,
                        input logic [31:0] d,
                        input logic [4:0] a,
                        input logic [31:0] ed,
                        input logic [2:0] ef);
    bus.iCMD = c;
    bus.iDATA = d;
    bus.iAMOUNT = a;
    drv_d = ed;
    drv_f = ef;
  endtask

  task automatic set_rnd;
    logic [2:0]  c;
    logic [31:0] d;
    logic [4:0]  a;
    logic [34:0] m;
    c = 3'($urandom_range(0, 7));
    d = $urandom;
    a = 5'($urandom_range(0, 31));
    m = model(c, d, a);
    set_op(c, d, a, m[31:0], m[34:32]);
  endtask

  task automatic issue_wait;
    int w;
    w = 0;
    bus.iVALID = 1'b1;
    @(negedge clk);
    while (bus.oBUSY && w < 100) begin
      w++;
      @(negedge clk);
    end
    if (w >= 100) begin
      n_tests++;
      n_fail++;
      $display("FAIL issue_timeout: got busy expected accept");
    end
    @(posedge clk);
    #1;
    bus.iVALID = 1'b0;
  endtask

  task automatic issue_rnd;
    set_rnd();
    issue_wait();
  endtask

  initial begin
    int start;
    int acc;
    bit took;
    bus.iVALID = 1'b0;
    bus.iBUSY = 1'b0;
    set_op(3'd0, 32'd0, 5'd0, 32'd0, 3'd0);

    tab[0]  = '{3'd1, 32'h8000_0001, 5'd1,  32'h0000_0002, 3'b010};
    tab[1]  = '{3'd3, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 3'b100};
    tab[2]  = '{3'd5, 32'h0000_0001, 5'd1,  32'h8000_0000, 3'b110};
    tab[3]  = '{3'd2, 32'h0000_0001, 5'd1,  32'h0000_0000, 3'b011};
    tab[4]  = '{3'd1, 32'h1234_5678, 5'd0,  32'h1234_5678, 3'b000};
    tab[5]  = '{3'd4, 32'h8000_0000, 5'd0,  32'h8000_0000, 3'b100};
    tab[6]  = '{3'd7, 32'hDEAD_BEEF, 5'd5,  32'hDEAD_BEEF, 3'b100};
    tab[7]  = '{3'd0, 32'h0000_0000, 5'd3,  32'h0000_0000, 3'b001};
    tab[8]  = '{3'd1, 32'h0000_0001, 5'd31, 32'h8000_0000, 3'b100};
    tab[9]  = '{3'd2, 32'h8000_0000, 5'd31, 32'h0000_0001, 3'b000};
    tab[10] = '{3'd4, 32'h8000_0001, 5'd4,  32'h0000_0018, 3'b000};
    tab[11] = '{3'd2, 32'h0000_00F0, 5'd8,  32'h0000_0000, 3'b011};
    tab[12] = '{3'd1, 32'h0100_0000, 5'd8,  32'h0000_0000, 3'b011};
    tab[13] = '{3'd3, 32'hF000_0000, 5'd16, 32'hFFFF_F000, 3'b100};
    tab[14] = '{3'd6, 32'h0000_0055, 5'd7,  32'h0000_0055, 3'b000};
    tab[15] = '{3'd5, 32'h0000_0100, 5'd9,  32'h8000_0000, 3'b110};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ovalid", 32'(bus.oVALID), 32'd0);
    chk("rst_odata", bus.oDATA, 32'd0);
    chk("rst_oflags", 32'(bus.oFLAGS), 32'd0);
    chk("rst_obusy", 32'(bus.oBUSY), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    chk_lat = 1;
    start = cyc;
    for (int i = 0; i < 16; i++) begin
      set_op(tab[i].c, tab[i].d, tab[i].a, tab[i].ed, tab[i].ef);
      issue_wait();
    end
    chk("table_cycles", 32'(cyc - start), 32'd16);
    repeat (4) @(posedge clk);
    #1;
    chk("table_drain", 32'(sb.size()), 32'd0);

    start = cyc;
    for (int i = 0; i < 8; i++) issue_rnd();
    chk("burst_cycles", 32'(cyc - start), 32'd8);
    repeat (4) @(posedge clk);
    #1;
    chk("burst_drain", 32'(sb.size()), 32'd0);
    chk_lat = 0;

    bus.iBUSY = 1'b1;
    acc = 0;
    set_rnd();
    bus.iVALID = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      took = !bus.oBUSY;
      if (took) acc++;
      @(posedge clk);
      #1;
      if (took) set_rnd();
    end
    chk("stall_accepts", 32'(acc), 32'(LAT));
    chk("stall_obusy", 32'(bus.oBUSY), 32'd1);
    bus.iVALID = 1'b0;
    bus.iBUSY = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("stall_drain", 32'(sb.size()), 32'd0);

    rnd_busy = 1;
    for (int i = 0; i < 30; i++) issue_rnd();
    rnd_busy = 0;
    @(posedge clk);
    #2;
    bus.iBUSY = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("rnd_drain", 32'(sb.size()), 32'd0);

    bus.iBUSY = 1'b1;
    for (int i = 0; i < LAT; i++) issue_rnd();
    set_rnd();
    bus.iVALID = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.iVALID = 1'b0;
    bus.iBUSY = 1'b0;
    @(negedge clk);
    chk("flush_ovalid", 32'(bus.oVALID), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    issue_rnd();
    repeat (4) @(posedge clk);
    #1;
    chk("flush_drain", 32'(sb.size()), 32'd0);

    bus.iBUSY = 1'b1;
    for (int i = 0; i < LAT; i++) begin
      set_op(3'd0, 32'hA5A5_0000 + 32'(i), 5'd0,
             32'hA5A5_0000 + 32'(i), 3'b100);
      issue_wait();
    end
    rst_sync = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    rst_sync = 1'b0;
    flush = 1'b0;
    chk("srst_ovalid", 32'(bus.oVALID), 32'd0);
    chk("srst_odata", bus.oDATA, 32'd0);
    chk("srst_oflags", 32'(bus.oFLAGS), 32'd0);
    chk("srst_obusy", 32'(bus.oBUSY), 32'd0);
    bus.iBUSY = 1'b0;

    for (int i = 0; i < 2; i++) begin
      set_op(3'd0, 32'h8765_4321, 5'd0, 32'h8765_4321, 3'b100);
      issue_wait();
    end
    set_op(3'd0, 32'h8765_4321, 5'd0, 32'h8765_4321, 3'b100);
    bus.iVALID = 1'b1;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_ovalid", 32'(bus.oVALID), 32'd0);
    chk("arst_odata", bus.oDATA, 32'd0);
    chk("arst_oflags", 32'(bus.oFLAGS), 32'd0);
    chk("arst_obusy", 32'(bus.oBUSY), 32'd0);
    bus.iVALID = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("arst_quiet", 32'(bus.oVALID), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
